// File: rtl/rom_weight_sequencer.sv
// rom_weight_sequencer: pairs activations with ROM weights, streams beats to a MAC, then fetches the bias
module rom_weight_sequencer #(
  parameter int DEPTH    = 3,
  parameter int WIDTH    = 8,
  parameter int N_INPUTS = 7
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  output logic             busy_o,
  output logic             done_o,
  input  logic [WIDTH-1:0] data_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic [DEPTH-1:0] rom_addr_o,
  input  logic [WIDTH-1:0] rom_data_i,
  output logic [WIDTH-1:0] act_o,
  output logic [WIDTH-1:0] weight_o,
  output logic             first_o,
  output logic             last_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] bias_o
);
  typedef enum logic [2:0] {IDLE, PRIME, RUN, BIAS, DRAIN} state_e;
  localparam logic [DEPTH-1:0] LAST_IDX  = DEPTH'(N_INPUTS - 1);
  localparam logic [DEPTH-1:0] BIAS_ADDR = DEPTH'(N_INPUTS);
  state_e           state_q, state_d;
  logic [DEPTH-1:0] cnt_q;
  logic [WIDTH-1:0] act_q, weight_q, bias_q;
  logic             valid_q, first_q, last_q;
  logic             out_free, accept, drain_ok;
  // Handshake, ROM address and next-state decode; the ROM is addressed one cycle ahead of use
  always_comb begin
    out_free   = !valid_q | ready_i;
    ready_o    = (state_q == RUN) & out_free;
    accept     = valid_i & ready_o;
    drain_ok   = (state_q == DRAIN) & out_free;
    done_o     = drain_ok;
    busy_o     = (state_q != IDLE) | valid_q;
    rom_addr_o = (state_q == RUN) ? (accept ? cnt_q + DEPTH'(1) : cnt_q) :
                 (state_q == BIAS || state_q == DRAIN) ? BIAS_ADDR : '0;
    state_d    = (state_q == IDLE && start_i) ? PRIME :
                 (state_q == PRIME) ? RUN :
                 (accept && cnt_q == LAST_IDX) ? BIAS :
                 (state_q == BIAS) ? DRAIN :
                 drain_ok ? IDLE : state_q;
  end
  // Sequencer state, index counter, output beat register and bias capture
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      act_q    <= '0;
      weight_q <= '0;
      bias_q   <= '0;
      valid_q  <= 1'b0;
      first_q  <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start_i) cnt_q <= '0;
      if (accept) begin
        act_q    <= data_i;
        weight_q <= rom_data_i;
        valid_q  <= 1'b1;
        first_q  <= (cnt_q == '0);
        last_q   <= (cnt_q == LAST_IDX);
        cnt_q    <= cnt_q + DEPTH'(1);
      end else if (ready_i) begin
        valid_q <= 1'b0;
      end
      if (state_q == BIAS) bias_q <= rom_data_i;
    end
  end
  assign act_o    = act_q;
  assign weight_o = weight_q;
  assign bias_o   = bias_q;
  assign valid_o  = valid_q;
  assign first_o  = first_q;
  assign last_o   = last_q;
endmodule

// File: tb/tb_rom_weight_sequencer.sv
// tb_rom_weight_sequencer: scoreboard bench for the ROM weight sequencer (N=7 and N=1 builds)
module tb_rom_weight_sequencer;
  localparam int N = 7;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic start_i = 0, valid_i = 0, ready_i = 0, busy_o, done_o, ready_o, first_o, last_o, valid_o;
  logic [7:0] data_i = 8'h10, rom_data, act_o, weight_o, bias_o;
  logic [2:0] rom_addr;
  logic [7:0] rom [8];
  rom_weight_sequencer #(.DEPTH(3), .WIDTH(8), .N_INPUTS(N)) dut (
    .clk_i(clk), .reset_i(rst), .start_i(start_i), .busy_o(busy_o), .done_o(done_o),
    .data_i(data_i), .valid_i(valid_i), .ready_o(ready_o), .rom_addr_o(rom_addr),
    .rom_data_i(rom_data), .act_o(act_o), .weight_o(weight_o), .first_o(first_o),
    .last_o(last_o), .valid_o(valid_o), .ready_i(ready_i), .bias_o(bias_o));
  always @(posedge clk) rom_data <= rom[rom_addr];
  logic s_start = 0, s_valid = 0, s_ready = 0, s_busy, s_done, s_rdy, s_first, s_last, s_vo;
  logic [7:0] s_data = 8'h42, s_rom_data, s_act, s_w, s_bias;
  logic [0:0] s_addr;
  rom_weight_sequencer #(.DEPTH(1), .WIDTH(8), .N_INPUTS(1)) dut1 (
    .clk_i(clk), .reset_i(rst), .start_i(s_start), .busy_o(s_busy), .done_o(s_done),
    .data_i(s_data), .valid_i(s_valid), .ready_o(s_rdy), .rom_addr_o(s_addr),
    .rom_data_i(s_rom_data), .act_o(s_act), .weight_o(s_w), .first_o(s_first),
    .last_o(s_last), .valid_o(s_vo), .ready_i(s_ready), .bias_o(s_bias));
  always @(posedge clk) s_rom_data <= s_addr ? 8'h99 : 8'h21;
  int tests = 0, fails = 0;
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask
  typedef struct {logic [7:0] a; int k;} beat_t;
  beat_t q[$];
  logic [7:0] log_a[$], log_w[$];
  logic log_f[$], log_l[$];
  int acc = 0, cons = 0, dones = 0, cyc = 0, done_cyc = 0, last_acc_cyc = 0;
  bit in_pass = 0, was_in, prev_stall = 0;
  logic [17:0] prev_beat;
  beat_t b;
  int s_beats = 0, s_dones = 0;
  always @(posedge clk) #1 data_i = 8'h10 + 8'(acc);
  // Scoreboard: derives every expectation from the pass rules (weight k = ROM[k] = k+1)
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      chk("rst_busy", busy_o, 0); chk("rst_done", done_o, 0); chk("rst_ready", ready_o, 0);
      chk("rst_addr", rom_addr, 0); chk("rst_act", act_o, 0); chk("rst_weight", weight_o, 0);
      chk("rst_flags", {first_o, last_o, valid_o}, 0); chk("rst_bias", bias_o, 0);
      q.delete(); acc = 0; cons = 0; in_pass = 0; prev_stall = 0;
    end else begin
      was_in = in_pass;
      if (prev_stall) chk("held_beat", {act_o, weight_o, first_o, last_o}, prev_beat);
      chk("busy", busy_o, in_pass | valid_o);
      if (ready_o && !(in_pass && acc < N)) chk("ready_out_of_pass", ready_o, 0);
      if (valid_o && ready_i) begin
        if (q.size() == 0) chk("spurious_beat", valid_o, 0);
        else begin
          b = q.pop_front();
          chk("beat_act", act_o, b.a);
          chk("beat_weight", weight_o, b.k + 1);
          chk("beat_first", first_o, b.k == 0);
          chk("beat_last", last_o, b.k == N - 1);
          log_a.push_back(act_o); log_w.push_back(weight_o);
          log_f.push_back(first_o); log_l.push_back(last_o);
        end
        cons++;
      end
      if (done_o) begin
        chk("done_in_pass", in_pass, 1);
        chk("done_all_accepted", acc, N);
        chk("done_all_consumed", cons, N);
        chk("done_bias", bias_o, 8'h55);
        dones++; done_cyc = cyc; in_pass = 0;
      end
      if (valid_i && ready_o) begin
        q.push_back('{a: data_i, k: acc});
        acc++;
        last_acc_cyc = cyc;
      end
      if (start_i && !was_in) begin
        in_pass = 1; acc = 0; cons = 0;
        log_a.delete(); log_w.delete(); log_f.delete(); log_l.delete();
      end
      prev_stall = valid_o & !ready_i;
      prev_beat = {act_o, weight_o, first_o, last_o};
    end
  end
  // N_INPUTS=1 build: single beat carrying both first and last, bias from addr 1
  always @(negedge clk) if (!rst) begin
    if (s_vo && s_ready) begin
      chk("n1_act", s_act, 8'h42); chk("n1_weight", s_w, 8'h21);
      chk("n1_first_last", {s_first, s_last}, 2'b11);
      s_beats++;
    end
    if (s_done) begin
      chk("n1_bias", s_bias, 8'h99); chk("n1_beats", s_beats, 1);
      s_dones++;
    end
  end
  task automatic tick();
    @(posedge clk); #1;
  endtask
  task automatic wait_done(input string nm, input int bound);
    int d0 = dones;
    for (int i = 0; i < bound && dones == d0; i++) tick();
    chk(nm, dones, d0 + 1);
  endtask
  task automatic start_pass();
    start_i = 1; tick(); start_i = 0;
  endtask
  initial begin
    for (int k = 0; k < 7; k++) rom[k] = 8'(k + 1);
    rom[7] = 8'h55;
    tick(); tick(); rst = 0;
    valid_i = 1; ready_i = 1;
    start_pass();
    wait_done("t1_done", 40);
    chk("t1_beat0", {log_a[0], log_w[0], log_f[0], log_l[0]}, {8'h10, 8'h01, 2'b10});
    chk("t1_beat6", {log_a[6], log_w[6], log_f[6], log_l[6]}, {8'h16, 8'h07, 2'b01});
    chk("t1_beats", log_a.size(), 7);
    chk("t1_done_gap", done_cyc - last_acc_cyc, 2);
    chk("t1_bias", bias_o, 8'h55);
    tick();
    start_pass();
    tick(); tick(); start_i = 1; tick(); start_i = 0;
    ready_i = 0; tick(); tick(); tick(); ready_i = 1;
    wait_done("t2_done", 40);
    chk("t2_beats", log_a.size(), 7);
    chk("t2_beat4", {log_a[4], log_w[4]}, {8'h14, 8'h05});
    tick();
    start_pass();
    for (int i = 0; i < 30 && dones < 3; i++) begin valid_i = ~valid_i; tick(); end
    valid_i = 1;
    chk("t3_done", dones, 3);
    chk("t3_beat3", {log_a[3], log_w[3]}, {8'h13, 8'h04});
    tick();
    start_pass();
    for (int i = 0; i < 30 && !(valid_o && last_o); i++) tick();
    chk("t4_last_seen", valid_o & last_o, 1);
    ready_i = 0; tick(); start_i = 1; tick(); tick(); start_i = 0; tick();
    chk("t4_no_early_done", dones, 3);
    ready_i = 1;
    wait_done("t4_done", 5);
    tick(); tick();
    chk("t4_single_done", dones, 4);
    chk("t4_idle", busy_o, 0);
    start_pass();
    for (int i = 0; i < 30 && cons < 3; i++) tick();
    chk("t6_three_beats", cons, 3);
    rst = 1; tick(); rst = 0;
    chk("t6_no_done", dones, 4);
    start_pass();
    wait_done("t6_done", 40);
    chk("t6_restart_beat0", {log_a[0], log_w[0], log_f[0]}, {8'h10, 8'h01, 1'b1});
    chk("t6_beats", log_a.size(), 7);
    s_valid = 1; s_ready = 1; s_start = 1; tick(); s_start = 0;
    for (int i = 0; i < 20 && s_dones == 0; i++) tick();
    chk("n1_done", s_dones, 1);
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
